// File: rtl/bootdata_pkg.sv
// bootdata_pkg
//   Shared definitions for the host-side ROM boot-data transmitter.
//   - state_t      : handshake FSM encoding (IDLE=0, REQ=1, REL=2)
//   - PAD_BYTE_DEF : default filler for unused lanes of a partial word
//   - LANE_W/LANES : lane counter width and lanes per 32-bit word
//   Byte order: little-endian; byte k of a word sits on bits [8k+7:8k].
package bootdata_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [7:0]  PAD_BYTE_DEF = 8'hFF;
    localparam int unsigned LANE_W       = 2;
    localparam int unsigned LANES        = 4;

endpackage

// File: rtl/bootdata_packer.sv
// bootdata_packer
//   Packs accepted bytes little-endian into 32-bit words and parks each
//   completed word in a single pending register until the FSM takes it.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     flush       : drop partial word and pending word (same effect as rst)
//     in_data     : byte to write
//     wr_en       : write in_data into the current lane
//     wr_last     : this byte closes the word (final byte of the image)
//     take        : FSM consumes the pending word this cycle
//     lane        : current lane 0..3
//     pend        : a completed word is waiting
//     pend_word   : the waiting word
//     pend_last   : the waiting word carried the final image byte
//     word_done   : a word completes on this edge
import bootdata_pkg::*;

module bootdata_packer #(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [7:0]        in_data,
    input  logic              wr_en,
    input  logic              wr_last,
    input  logic              take,
    output logic [LANE_W-1:0] lane,
    output logic              pend,
    output logic [31:0]       pend_word,
    output logic              pend_last,
    output logic              word_done
);

    logic [31:0] pack;
    logic [31:0] merged;

    // Pack register with the incoming byte already placed in its lane.
    always_comb begin
        merged = pack;
        merged[{lane, 3'b000} +: 8] = in_data;
    end

    assign word_done = wr_en && ((lane == 2'd3) || wr_last);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lane      <= '0;
            pack      <= {LANES{PAD_BYTE}};
            pend      <= 1'b0;
            pend_word <= '0;
            pend_last <= 1'b0;
        end else begin
            if (take)
                pend <= 1'b0;
            if (word_done) begin
                pend_word <= merged;
                pend_last <= wr_last;
                pend      <= 1'b1;
                lane      <= '0;
                pack      <= {LANES{PAD_BYTE}};
            end else if (wr_en) begin
                pack[{lane, 3'b000} +: 8] <= in_data;
                lane <= lane + 2'd1;
            end
        end
    end

endmodule

// File: rtl/bootdata_host_tx.sv
// bootdata_host_tx
//   Host-side transmitter for the 32-bit ROM boot-data channel. Packs the
//   host byte stream into words and delivers each over a four-phase
//   req/ack handshake (host_bootdata / host_bootdata_req / _ack).
//   Optional feature macro: BOOTDATA_TIMEOUT_EN (ack wait limit).
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     in_data/valid/last : host byte stream, in_ready back-pressure
//     host_bootdata      : word to core (byte k on bits [8k+7:8k])
//     host_bootdata_req  : four-phase request; host_bootdata_ack from core
//     words_sent         : words whose ack fall has been observed
//     busy               : word pending, partial word, or handshake active
//     done               : sticky, final word handshaken
//     overflow           : sticky, byte dropped beyond MAX_WORDS
//     timeout_err        : sticky ack timeout (tied 0 without the macro)
import bootdata_pkg::*;

module bootdata_host_tx #(
    parameter int unsigned MAX_WORDS   = 16384,
    parameter int unsigned WCNT_W      = 15,
    parameter logic [7:0]  PAD_BYTE    = 8'hFF
`ifdef BOOTDATA_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [31:0]       host_bootdata,
    output logic              host_bootdata_req,
    input  logic              host_bootdata_ack,
    output logic [WCNT_W-1:0] words_sent,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              timeout_err
);

    state_t              state;
    logic                inflight_last;
    logic [WCNT_W-1:0]   words_made;
    logic                at_limit;
    logic                stream_off;
    logic                discard;
    logic                accept;
    logic                wr_en;
    logic                take;
    logic                flush;
    logic [LANE_W-1:0]   lane;
    logic                pend;
    logic [31:0]         pend_word;
    logic                pend_last;
    logic                word_done;

    // words_made counts words produced (sent + pending + in flight).
    assign at_limit = (words_made == WCNT_W'(MAX_WORDS));
    // In discard mode bytes are still accepted but never reach the packer.
    assign discard  = done || at_limit || stream_off;
    assign in_ready = discard || !pend;
    assign accept   = in_valid && in_ready;
    assign wr_en    = accept && !discard && !flush;
    assign take     = (state == IDLE) && pend;
    assign busy     = pend || (state != IDLE) || (lane != '0);

    bootdata_packer #(
        .PAD_BYTE (PAD_BYTE)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_last   (in_last),
        .take      (take),
        .lane      (lane),
        .pend      (pend),
        .pend_word (pend_word),
        .pend_last (pend_last),
        .word_done (word_done)
    );

`ifdef BOOTDATA_TIMEOUT_EN
    logic [15:0] tcnt;
    logic        timeout_hit;
    assign timeout_hit = (state != IDLE) && (tcnt == 16'(TIMEOUT_CYC - 1));
    assign flush       = timeout_hit;
`else
    assign flush       = 1'b0;
    assign stream_off  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            host_bootdata     <= '0;
            host_bootdata_req <= 1'b0;
            inflight_last     <= 1'b0;
            words_sent        <= '0;
            words_made        <= '0;
            done              <= 1'b0;
            overflow          <= 1'b0;
`ifdef BOOTDATA_TIMEOUT_EN
            tcnt              <= '0;
            timeout_err       <= 1'b0;
            stream_off        <= 1'b0;
`endif
        end else begin
            if (word_done)
                words_made <= words_made + WCNT_W'(1);
            if (accept && at_limit && !done && !stream_off) begin
                overflow <= 1'b1;
                // The final byte still ends the load even though it is dropped.
                if (in_last)
                    done <= 1'b1;
            end
`ifdef BOOTDATA_TIMEOUT_EN
            tcnt <= (state == IDLE) ? '0 : tcnt + 16'd1;
`endif
            unique case (state)
                IDLE: begin
                    if (pend) begin
                        host_bootdata     <= pend_word;
                        inflight_last     <= pend_last;
                        host_bootdata_req <= 1'b1;
                        state             <= REQ;
                    end
                end
                REQ: begin
                    if (host_bootdata_ack) begin
                        host_bootdata_req <= 1'b0;
                        state             <= REL;
`ifdef BOOTDATA_TIMEOUT_EN
                        tcnt              <= '0;
`endif
                    end
                end
                REL: begin
                    if (!host_bootdata_ack) begin
                        words_sent <= words_sent + WCNT_W'(1);
                        if (inflight_last)
                            done <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef BOOTDATA_TIMEOUT_EN
            // Timeout overrides whatever the handshake did this cycle.
            if (timeout_hit) begin
                timeout_err       <= 1'b1;
                stream_off        <= 1'b1;
                host_bootdata_req <= 1'b0;
                state             <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bootdata_host_tx.sv
// tb_bootdata_host_tx
//   Scoreboard bench for bootdata_host_tx. Two instances: A with default
//   parameters, B with MAX_WORDS=2 (and TIMEOUT_CYC=20 when
//   BOOTDATA_TIMEOUT_EN is defined). sel picks the instance under test.
module tb_bootdata_host_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        sel;
    logic        ack;
    logic        ack_en;
    int unsigned ack_dly;

    logic        in_valid_a, in_valid_b, ack_a, ack_b;
    logic        rdy_a, rdy_b, req_a, req_b;
    logic [31:0] data_a, data_b;
    logic [14:0] ws_a, ws_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b, to_a, to_b;

    logic        rdy_s, req_s, busy_s, done_s, ovf_s, to_s;
    logic [31:0] data_s;
    logic [14:0] ws_s;

    int          checks   = 0;
    int          failures = 0;
    int          stalls   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign in_valid_a = in_valid && !sel;
    assign in_valid_b = in_valid && sel;
    assign ack_a      = ack && !sel;
    assign ack_b      = ack && sel;
    assign rdy_s      = sel ? rdy_b  : rdy_a;
    assign req_s      = sel ? req_b  : req_a;
    assign data_s     = sel ? data_b : data_a;
    assign ws_s       = sel ? ws_b   : ws_a;
    assign busy_s     = sel ? busy_b : busy_a;
    assign done_s     = sel ? done_b : done_a;
    assign ovf_s      = sel ? ovf_b  : ovf_a;
    assign to_s       = sel ? to_b   : to_a;

    bootdata_host_tx dut_a (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid_a),
        .in_last           (in_last),
        .in_ready          (rdy_a),
        .host_bootdata     (data_a),
        .host_bootdata_req (req_a),
        .host_bootdata_ack (ack_a),
        .words_sent        (ws_a),
        .busy              (busy_a),
        .done              (done_a),
        .overflow          (ovf_a),
        .timeout_err       (to_a)
    );

    bootdata_host_tx #(
        .MAX_WORDS (2)
`ifdef BOOTDATA_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (20)
`endif
    ) dut_b (
        .clk               (clk),
        .rst               (rst),
        .in_data           (in_data),
        .in_valid          (in_valid_b),
        .in_last           (in_last),
        .in_ready          (rdy_b),
        .host_bootdata     (data_b),
        .host_bootdata_req (req_b),
        .host_bootdata_ack (ack_b),
        .words_sent        (ws_b),
        .busy              (busy_b),
        .done              (done_b),
        .overflow          (ovf_b),
        .timeout_err       (to_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: raises ack ack_dly cycles after req, drops it after req falls.
    initial begin
        int unsigned cnt;
        ack = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !ack_en) begin
                ack = 1'b0;
                cnt = 0;
            end else if (!ack && req_s) begin
                if (cnt >= ack_dly) begin
                    ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if (ack && !req_s) begin
                ack = 1'b0;
            end
        end
    end

    // Monitor: each req rise pops the expected word; data must stay put
    // until the handshake completes.
    initial begin
        logic        req_prev;
        logic [31:0] held;
        logic [31:0] exp;
        req_prev = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (req_s && !req_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", data_s);
                end else begin
                    exp = exp_q.pop_front();
                    chk("word_data", data_s, exp);
                end
                held = data_s;
            end else if (req_s || ack) begin
                chk("data_stable", data_s, held);
            end
            req_prev = req_s;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int unsigned n;
        n        = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!rdy_s && n < 500) begin
            @(negedge clk);
            n++;
        end
        stalls += int'(n);
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got stalled expected accept");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((busy_s || req_s || ack) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic wait_req();
        int unsigned n;
        n = 0;
        while (!req_s && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: got 0 expected 1");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sel      = 1'b0;
        ack_en   = 1'b1;
        ack_dly  = 2;
        do_reset();

        // Reset state
        chk("rst_data",     data_s, 32'h0);
        chk("rst_req",      32'(req_s), 32'd0);
        chk("rst_ready",    32'(rdy_s), 32'd1);
        chk("rst_words",    32'(ws_s), 32'd0);
        chk("rst_busy",     32'(busy_s), 32'd0);
        chk("rst_done",     32'(done_s), 32'd0);
        chk("rst_overflow", 32'(ovf_s), 32'd0);
        chk("rst_timeout",  32'(to_s), 32'd0);

        // Full word with last on lane 3
        exp_q.push_back(32'h44332211);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_idle();
        chk("t1_words", 32'(ws_s), 32'd1);
        chk("t1_done",  32'(done_s), 32'd1);
        // After done: bytes are swallowed without forming a word
        stalls = 0;
        send_byte(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        chk("t1_post_stall", 32'(stalls), 32'd0);
        chk("t1_post_words", 32'(ws_s), 32'd1);
        chk("t1_post_busy",  32'(busy_s), 32'd0);

        // Partial word padded with FF
        do_reset();
        exp_q.push_back(32'hFFFFBBAA);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        wait_idle();
        chk("t2_words", 32'(ws_s), 32'd1);
        chk("t2_done",  32'(done_s), 32'd1);

        // Continuous stream with slow core: back-pressure, no loss
        do_reset();
        ack_dly = 10;
        stalls  = 0;
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h07060504);
        exp_q.push_back(32'h0B0A0908);
        for (int i = 0; i < 12; i++)
            send_byte(8'(i), (i == 11) ? 1'b1 : 1'b0);
        wait_idle();
        chk("t3_stalled",  32'(stalls > 0), 32'd1);
        chk("t3_words",    32'(ws_s), 32'd3);
        chk("t3_done",     32'(done_s), 32'd1);
        chk("t3_overflow", 32'(ovf_s), 32'd0);
        ack_dly = 2;

        // Reset while in REQ with ack low
        do_reset();
        ack_en = 1'b0;
        exp_q.push_back(32'hA4A3A2A1);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b1);
        wait_req();
        rst = 1'b1;
        @(negedge clk);
        chk("t4_req",   32'(req_s), 32'd0);
        chk("t4_busy",  32'(busy_s), 32'd0);
        chk("t4_words", 32'(ws_s), 32'd0);
        rst    = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h04030201);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        wait_idle();
        chk("t4_words2", 32'(ws_s), 32'd1);
        chk("t4_done2",  32'(done_s), 32'd1);

        // MAX_WORDS=2 instance: overflow, no stall after the limit
        sel = 1'b1;
        do_reset();
        ack_dly = 3;
        exp_q.push_back(32'h13121110);
        exp_q.push_back(32'h17161514);
        for (int i = 0; i < 12; i++) begin
            if (i == 8)
                stalls = 0;
            send_byte(8'(8'h10 + i), (i == 11) ? 1'b1 : 1'b0);
        end
        chk("t5_stall_after_limit", 32'(stalls), 32'd0);
        wait_idle();
        chk("t5_words",    32'(ws_s), 32'd2);
        chk("t5_overflow", 32'(ovf_s), 32'd1);
        chk("t5_done",     32'(done_s), 32'd1);
        ack_dly = 2;

`ifdef BOOTDATA_TIMEOUT_EN
        // Core never acks: timeout after 20 REQ cycles
        do_reset();
        ack_en = 1'b0;
        exp_q.push_back(32'h24232221);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        send_byte(8'h24, 1'b1);
        wait_req();
        begin
            int unsigned n;
            n = 0;
            while (!to_s && n < 100) begin
                if (req_s)
                    n++;
                @(negedge clk);
            end
            chk("t6_req_cycles", 32'(n), 32'd20);
        end
        chk("t6_timeout", 32'(to_s), 32'd1);
        chk("t6_req",     32'(req_s), 32'd0);
        chk("t6_ready",   32'(rdy_s), 32'd1);
        chk("t6_busy",    32'(busy_s), 32'd0);
        ack_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
